// File: rtl/ctrl_hazard_unit_pkg.sv
// Shared constants and decode helpers for the control-hazard unit:
// opcodes, funct3 codes, one-hot branch-type layout and immediate extraction.
package ctrl_hazard_unit_pkg;

  localparam int DATA_W  = 32;
  localparam int BC_BITS = 6;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Bit positions inside the one-hot branch-type code.
  localparam int BC_BEQ  = 0;
  localparam int BC_BNE  = 1;
  localparam int BC_BLT  = 2;
  localparam int BC_BGE  = 3;
  localparam int BC_BLTU = 4;
  localparam int BC_BGEU = 5;

  typedef logic [BC_BITS-1:0] bc_t;

  localparam bc_t BC_BEQ_OH  = bc_t'(1 << BC_BEQ);
  localparam bc_t BC_BNE_OH  = bc_t'(1 << BC_BNE);
  localparam bc_t BC_BLT_OH  = bc_t'(1 << BC_BLT);
  localparam bc_t BC_BGE_OH  = bc_t'(1 << BC_BGE);
  localparam bc_t BC_BLTU_OH = bc_t'(1 << BC_BLTU);
  localparam bc_t BC_BGEU_OH = bc_t'(1 << BC_BGEU);

  function automatic logic [DATA_W-1:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // funct3 010/011 are not branches and map to the all-zero code.
  function automatic bc_t f3_to_bc(input logic [2:0] f3);
    bc_t bc;
    case (f3)
      F3_BEQ:  bc = BC_BEQ_OH;
      F3_BNE:  bc = BC_BNE_OH;
      F3_BLT:  bc = BC_BLT_OH;
      F3_BGE:  bc = BC_BGE_OH;
      F3_BLTU: bc = BC_BLTU_OH;
      F3_BGEU: bc = BC_BGEU_OH;
      default: bc = '0;
    endcase
    return bc;
  endfunction

endpackage

// File: rtl/ctrl_hazard_unit_branch_cond.sv
// Branch outcome from the ALU flags of rs1-rs2 and the one-hot branch type.
// Zero or multi-hot codes resolve as not taken.
module ctrl_hazard_unit_branch_cond
  import ctrl_hazard_unit_pkg::*;
(
  input  logic nf,
  input  logic zf,
  input  logic cf,
  input  logic vf,
  input  bc_t  bra_control,
  output logic taken
);

  logic lt_signed;

  assign lt_signed = nf ^ vf;

  // cf=1 means no borrow, i.e. rs1 >= rs2 unsigned.
  always_comb begin
    taken = 1'b0;
    case (bra_control)
      BC_BEQ_OH:  taken = zf;
      BC_BNE_OH:  taken = ~zf;
      BC_BLT_OH:  taken = lt_signed;
      BC_BGE_OH:  taken = ~lt_signed;
      BC_BLTU_OH: taken = ~cf;
      BC_BGEU_OH: taken = cf;
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_hazard_unit.sv
// Control-hazard unit: static prediction in ID, branch/JALR resolution in EX,
// PC-select and flush generation, plus a one-cycle redirect lock.
module ctrl_hazard_unit
  import ctrl_hazard_unit_pkg::*;
#(
  parameter int XLEN = DATA_W,
  parameter int BC_W = BC_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            branch,
  input  logic [XLEN-1:0] bra_pc,
  input  logic [XLEN-1:0] bra_imm,
  input  logic            NF,
  input  logic            ZF,
  input  logic            CF,
  input  logic            VF,
  input  logic [BC_W-1:0] i_bra_control,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic            address_src,
  output logic [XLEN-1:0] predict_pc,
  output logic [XLEN-1:0] predict_err_pc,
  output logic            register_rst,
  output logic            pc_src,
  output logic            lock,
  output logic [BC_W-1:0] o_bra_control
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  bc_t             dec_bc;
  logic            dec_as;
  logic            taken;
  logic            predicted;
  logic            mispredict;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] bra_target;
  logic [XLEN-1:0] jalr_sum;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Decode-side static prediction: JAL always taken, branches taken when backward.
  always_comb begin
    dec_bc     = '0;
    dec_as     = 1'b0;
    predict_pc = pc + XLEN'(4);
    case (opcode)
      OP_BRANCH: begin
        dec_bc = f3_to_bc(funct3);
        if (dec_bc != '0) begin
          predict_pc = pc + b_imm(inst);
          dec_as     = inst[31];
        end
      end
      OP_JAL: begin
        predict_pc = pc + j_imm(inst);
        dec_as     = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_bra_control = dec_bc;
  // A redirect now or in the previous cycle makes the ID instruction stale.
  assign address_src   = dec_as & ~pc_src & ~lock;

  ctrl_hazard_unit_branch_cond u_branch_cond (
    .nf          (NF),
    .zf          (ZF),
    .cf          (CF),
    .vf          (VF),
    .bra_control (i_bra_control),
    .taken       (taken)
  );

  assign predicted  = bra_imm[XLEN-1];
  assign mispredict = branch & (taken != predicted);

  assign seq_pc     = bra_pc + XLEN'(4);
  assign bra_target = bra_pc + bra_imm;
  assign jalr_sum   = rs1_data + jalr_imm;

  // JALR has no ID-side prediction, so it always redirects and outranks a branch.
  always_comb begin
    predict_err_pc = seq_pc;
    pc_src         = 1'b0;
    if (jalr_en) begin
      predict_err_pc = {jalr_sum[XLEN-1:1], 1'b0};
      pc_src         = 1'b1;
    end else if (mispredict) begin
      predict_err_pc = taken ? bra_target : seq_pc;
      pc_src         = 1'b1;
    end
  end

  assign register_rst = pc_src;

  always_ff @(posedge clk) begin
    if (rst) lock <= 1'b0;
    else     lock <= pc_src;
  end

endmodule

// File: tb/tb_ctrl_hazard_unit.sv
// Bench for ctrl_hazard_unit: vector table through a scoreboard queue, plus
// hand-built sequences for lock behaviour across redirects and reset.
module tb_ctrl_hazard_unit;

  localparam int W = 73;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        branch;
    logic [31:0] bra_pc;
    logic [31:0] bra_imm;
    logic [3:0]  flags;   // {NF,ZF,CF,VF}
    logic [5:0]  bc;
    logic        jalr_en;
    logic [31:0] jalr_imm;
    logic [31:0] rs1;
    logic        e_as;    // decode prediction before lock/pc_src masking
    logic [31:0] e_ppc;
    logic        chk_ppc;
    logic [31:0] e_epc;
    logic        e_psrc;
    logic [5:0]  e_bc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, inst, bra_pc, bra_imm, jalr_imm, rs1_data;
  logic        branch, NF, ZF, CF, VF, jalr_en;
  logic [5:0]  i_bra_control;
  logic        address_src, register_rst, pc_src, lock;
  logic [31:0] predict_pc, predict_err_pc;
  logic [5:0]  o_bra_control;

  logic [W-1:0] exp_q[$];
  logic         lock_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  vec_t         tbl[15];

  ctrl_hazard_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .inst           (inst),
    .branch         (branch),
    .bra_pc         (bra_pc),
    .bra_imm        (bra_imm),
    .NF             (NF),
    .ZF             (ZF),
    .CF             (CF),
    .VF             (VF),
    .i_bra_control  (i_bra_control),
    .jalr_en        (jalr_en),
    .jalr_imm       (jalr_imm),
    .rs1_data       (rs1_data),
    .address_src    (address_src),
    .predict_pc     (predict_pc),
    .predict_err_pc (predict_err_pc),
    .register_rst   (register_rst),
    .pc_src         (pc_src),
    .lock           (lock),
    .o_bra_control  (o_bra_control)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [31:0] p, input logic [31:0] in, input logic br,
    input logic [31:0] bp, input logic [31:0] bi, input logic [3:0] fl,
    input logic [5:0] bc, input logic je, input logic [31:0] ji, input logic [31:0] r1,
    input logic eas, input logic [31:0] eppc, input logic cppc,
    input logic [31:0] eepc, input logic epsrc, input logic [5:0] ebc);
    vec_t v;
    v.pc = p; v.inst = in; v.branch = br; v.bra_pc = bp; v.bra_imm = bi;
    v.flags = fl; v.bc = bc; v.jalr_en = je; v.jalr_imm = ji; v.rs1 = r1;
    v.e_as = eas; v.e_ppc = eppc; v.chk_ppc = cppc; v.e_epc = eepc;
    v.e_psrc = epsrc; v.e_bc = ebc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: check lock from the last edge, apply one vector, score comb outputs
  task automatic drive_cycle(input vec_t v, input logic r);
    logic [W-1:0] e;
    logic         el;
    logic         e_as_eff;
    @(posedge clk);
    #1;
    el = lock_q.pop_front();
    chk("lock", {31'd0, lock}, {31'd0, el});
    rst = r;
    pc = v.pc; inst = v.inst; branch = v.branch; bra_pc = v.bra_pc; bra_imm = v.bra_imm;
    {NF, ZF, CF, VF} = v.flags; i_bra_control = v.bc;
    jalr_en = v.jalr_en; jalr_imm = v.jalr_imm; rs1_data = v.rs1;
    e_as_eff = v.e_as & ~v.e_psrc & ~el;
    exp_q.push_back({e_as_eff, v.chk_ppc, v.e_ppc, v.e_epc, v.e_psrc, v.e_bc});
    lock_q.push_back(r ? 1'b0 : v.e_psrc);
    #3;
    e = exp_q.pop_front();
    chk("address_src", {31'd0, address_src}, {31'd0, e[72]});
    if (e[71]) chk("predict_pc", predict_pc, e[70:39]);
    chk("predict_err_pc", predict_err_pc, e[38:7]);
    chk("pc_src", {31'd0, pc_src}, {31'd0, e[6]});
    chk("register_rst", {31'd0, register_rst}, {31'd0, e[6]});
    chk("o_bra_control", {26'd0, o_bra_control}, {26'd0, e[5:0]});
  endtask

  initial begin
    vec_t idle, red_beq, red_jalr, beq_back;
    // pc inst br bra_pc bra_imm {N,Z,C,V} bc jalr jimm rs1 | as ppc chk epc psrc bc
    tbl[0]  = mk(32'h100, 32'hFE000EE3, 0, 32'h0, 32'h0, 4'b0000, 6'b000000, 0, 0, 0,
                 1, 32'h0FC, 1, 32'h4, 0, 6'b000001);
    tbl[1]  = mk(32'h100, 32'h00001463, 0, 32'h0, 32'h0, 4'b0000, 6'b000000, 0, 0, 0,
                 0, 32'h108, 1, 32'h4, 0, 6'b000010);
    tbl[2]  = mk(32'h100, 32'h0080006F, 0, 32'h0, 32'h0, 4'b0000, 6'b000000, 0, 0, 0,
                 1, 32'h108, 1, 32'h4, 0, 6'b000000);
    tbl[3]  = mk(32'h100, 32'h00000013, 1, 32'h200, 32'h10, 4'b0100, 6'b000001, 0, 0, 0,
                 0, 32'h104, 1, 32'h210, 1, 6'b000000);
    tbl[4]  = mk(32'h100, 32'h00000013, 1, 32'h300, 32'hFFFFFFF0, 4'b0000, 6'b000100, 0, 0, 0,
                 0, 32'h104, 1, 32'h304, 1, 6'b000000);
    tbl[5]  = mk(32'h100, 32'h00000013, 1, 32'h300, 32'hFFFFFFF0, 4'b0010, 6'b100000, 0, 0, 0,
                 0, 32'h104, 1, 32'h304, 0, 6'b000000);
    tbl[6]  = mk(32'h100, 32'h00000013, 1, 32'h200, 32'h10, 4'b0100, 6'b000001, 1, 32'h4, 32'h1001,
                 0, 32'h104, 1, 32'h1004, 1, 6'b000000);
    tbl[7]  = mk(32'h100, 32'hFE002EE3, 0, 32'h0, 32'h0, 4'b0000, 6'b000000, 0, 0, 0,
                 0, 32'h0, 0, 32'h4, 0, 6'b000000);
    tbl[8]  = mk(32'h100, 32'h00000013, 1, 32'h400, 32'h20, 4'b0000, 6'b010000, 0, 0, 0,
                 0, 32'h104, 1, 32'h420, 1, 6'b000000);
    tbl[9]  = mk(32'h100, 32'h00000013, 1, 32'h500, 32'hFFFFFFF8, 4'b0100, 6'b000010, 0, 0, 0,
                 0, 32'h104, 1, 32'h504, 1, 6'b000000);
    tbl[10] = mk(32'h100, 32'h00000013, 1, 32'h600, 32'h40, 4'b0100, 6'b000000, 0, 0, 0,
                 0, 32'h104, 1, 32'h604, 0, 6'b000000);
    tbl[11] = mk(32'h100, 32'h00000013, 1, 32'h700, 32'h40, 4'b0110, 6'b000011, 0, 0, 0,
                 0, 32'h104, 1, 32'h704, 0, 6'b000000);
    tbl[12] = mk(32'h100, 32'h00000013, 0, 32'h0, 32'h0, 4'b0000, 6'b000000, 1, 32'h3, 32'hFFFFFFFF,
                 0, 32'h104, 1, 32'h2, 1, 6'b000000);
    tbl[13] = mk(32'h0, 32'hFE000EE3, 0, 32'h0, 32'h0, 4'b0000, 6'b000000, 0, 0, 0,
                 1, 32'hFFFFFFFC, 1, 32'h4, 0, 6'b000001);
    tbl[14] = mk(32'h100, 32'h00000013, 1, 32'h800, 32'h8, 4'b1001, 6'b001000, 0, 0, 0,
                 0, 32'h104, 1, 32'h808, 1, 6'b000000);

    idle     = mk(32'h0, 32'h00000013, 0, 32'h0, 32'h0, 4'b0000, 6'b000000, 0, 0, 0,
                  0, 32'h4, 1, 32'h4, 0, 6'b000000);
    red_beq  = tbl[3];
    red_jalr = tbl[12];
    beq_back = tbl[0];

    rst = 1'b1;
    pc = '0; inst = 32'h13; branch = 0; bra_pc = '0; bra_imm = '0;
    {NF, ZF, CF, VF} = 4'b0; i_bra_control = '0; jalr_en = 0; jalr_imm = '0; rs1_data = '0;
    repeat (2) @(posedge clk);
    lock_q.push_back(1'b0);
    drive_cycle(idle, 1'b0);

    // table vectors, each followed by an idle cycle so lock retires
    for (int i = 0; i < 15; i++) begin
      drive_cycle(tbl[i], 1'b0);
      drive_cycle(idle, 1'b0);
    end

    // back-to-back redirects keep lock high; predict suppressed while locked
    drive_cycle(red_beq, 1'b0);
    drive_cycle(red_jalr, 1'b0);
    drive_cycle(beq_back, 1'b0);
    chk("as_under_lock", {31'd0, address_src}, 32'd0);
    drive_cycle(idle, 1'b0);

    // reset at an edge while pc_src=1 clears lock; comb outputs unaffected
    drive_cycle(red_beq, 1'b1);
    drive_cycle(red_beq, 1'b0);
    drive_cycle(idle, 1'b0);

    // a few random idle/redirect mixes exercising lock tracking
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) drive_cycle(tbl[$urandom_range(0, 14)], 1'b0);
      else drive_cycle(idle, 1'b0);
    end

    @(posedge clk);
    #1;
    chk("lock_final", {31'd0, lock}, {31'd0, lock_q.pop_front()});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
